xbus_arbiter: RTL



---
 rtl/xbus_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/xbus_arbiter.sv
// xbus_arbiter: shares one blocking XBus channel among N_PORT MCX cores.
// A writer is granted round-robin, its word is held until another core
// reads it, and both sides receive a one-cycle acknowledge pulse.
// Optional feature macro: XBUS_TIMEOUT_EN. When defined, a held word is
// dropped after TIMEOUT HOLD cycles without a reader and wr_err pulses.
//
// Handshake: wr_req/rd_req are levels held until the matching ack pulse
// or withdrawn; wr_ack/rd_ack are single-cycle pulses, and rd_data is
// valid in the cycle rd_ack is high and holds until the next delivery.
module xbus_arbiter #(
  parameter int N_PORT  = 4,
  parameter int DW      = 11,
  parameter int IW      = 3,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic [N_PORT-1:0]    wr_req,
  input  logic [N_PORT*DW-1:0] wr_data,
  input  logic [N_PORT-1:0]    rd_req,
  output logic [N_PORT-1:0]    wr_ack,
  output logic [N_PORT-1:0]    rd_ack,
  output logic [DW-1:0]        rd_data,
  output logic                 busy,
  output logic [IW-1:0]        owner,
  output logic [N_PORT-1:0]    wr_err,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, DONE = 2'd2} state_t;

  localparam logic [IW:0] NP = (IW+1)'(N_PORT);
  localparam logic [N_PORT-1:0] ONE = {{(N_PORT-1){1'b0}}, 1'b1};

  if (TIMEOUT < 1 || (1 << IW) < N_PORT) begin : g_cfg_check
    $error("xbus_arbiter: invalid TIMEOUT/IW/N_PORT combination");
  end

  state_t              state_q;
  logic [IW-1:0]       wr_ptr_q, rd_ptr_q, owner_q;
  logic [DW-1:0]       word_q, rd_data_q;
  logic [N_PORT-1:0]   wr_ack_q, rd_ack_q;
  logic                busy_q;

  logic [IW-1:0]       wr_sel, rd_sel;
  logic [N_PORT-1:0]   owner_oh, rd_elig;

  // Index of the first set request at or after ptr, wrapping modulo N_PORT.
  function automatic logic [IW-1:0] rr_pick(input logic [N_PORT-1:0] req,
                                            input logic [IW-1:0] ptr);
    logic [IW-1:0] sel;
    logic [IW:0]   idx;
    sel = '0;
    for (int k = N_PORT-1; k >= 0; k--) begin
      idx = {1'b0, ptr} + k[IW:0];
      if (idx >= NP) idx = idx - NP;
      if (req[idx[IW-1:0]]) sel = idx[IW-1:0];
    end
    return sel;
  endfunction

  // Successor index modulo N_PORT.
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    logic [IW:0] n;
    n = {1'b0, idx} + 1'b1;
    if (n >= NP) n = '0;
    return n[IW-1:0];
  endfunction

  // Arbitration decisions; readers exclude the owner so a core never reads its own word.
  always_comb begin
    owner_oh = ONE << owner_q;
    rd_elig  = rd_req & ~owner_oh;
    wr_sel   = rr_pick(wr_req, wr_ptr_q);
    rd_sel   = rr_pick(rd_elig, rd_ptr_q);
  end

`ifdef XBUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0]     cnt_q;
  logic [N_PORT-1:0] wr_err_q;
`endif

  // Channel FSM with all outputs registered; reset wins in every state.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      owner_q   <= '0;
      word_q    <= '0;
      rd_data_q <= '0;
      wr_ack_q  <= '0;
      rd_ack_q  <= '0;
      busy_q    <= 1'b0;
`ifdef XBUS_TIMEOUT_EN
      cnt_q     <= '0;
      wr_err_q  <= '0;
`endif
    end else begin
      wr_ack_q <= '0;
      rd_ack_q <= '0;
`ifdef XBUS_TIMEOUT_EN
      wr_err_q <= '0;
`endif
      case (state_q)
        IDLE: begin
          if (|wr_req) begin
            owner_q  <= wr_sel;
            word_q   <= wr_data[wr_sel*DW +: DW];
            wr_ptr_q <= next_idx(wr_sel);
            busy_q   <= 1'b1;
            state_q  <= HOLD;
`ifdef XBUS_TIMEOUT_EN
            cnt_q    <= '0;
`endif
          end
        end
        HOLD: begin
          if (!wr_req[owner_q]) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (|rd_elig) begin
            rd_data_q <= word_q;
            rd_ack_q  <= ONE << rd_sel;
            wr_ack_q  <= owner_oh;
            rd_ptr_q  <= next_idx(rd_sel);
            state_q   <= DONE;
          end
`ifdef XBUS_TIMEOUT_EN
          else if (cnt_q == T_LAST) begin
            wr_err_q <= owner_oh;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign wr_ack    = wr_ack_q;
  assign rd_ack    = rd_ack_q;
  assign rd_data   = rd_data_q;
  assign busy      = busy_q;
  assign owner     = owner_q;
  assign state_dbg = state_q;
`ifdef XBUS_TIMEOUT_EN
  assign wr_err    = wr_err_q;
`else
  assign wr_err    = '0;
`endif

endmodule
